// File: rtl/memwb_writeback_unit.sv
// MEM/WB pipeline register with registered load formatting, lane selection and write-back gating.
// Define WB_UNALIGNED_EN to compile in LWL/LWR merging (requires BITS_SIZE = 32).
module memwb_writeback_unit #(
  parameter int BITS_SIZE      = 32,
  parameter int BITS_REGS      = 5,
  parameter int BYTE_BITS_SIZE = 8,
  parameter int BITS_COUNT     = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_reg_write,
  input  logic [BITS_REGS-1:0]  i_rd,
  input  logic                  i_mem_to_reg,
  input  logic                  i_lui,
  input  logic                  i_zero_extend,
  input  logic [2:0]            i_load_mode,
  input  logic [1:0]            i_addr_offset,
  input  logic [BITS_SIZE-1:0]  i_dato_mem,
  input  logic [BITS_SIZE-1:0]  i_alu,
  input  logic [BITS_SIZE-1:0]  i_extension,
  input  logic [BITS_SIZE-1:0]  i_rt_old,
  output logic                  o_valid,
  output logic                  o_reg_write,
  output logic [BITS_REGS-1:0]  o_rd,
  output logic [BITS_SIZE-1:0]  o_data_write,
  output logic                  o_fault,
  output logic [BITS_COUNT-1:0] o_retired
);

  localparam int HALF_W = 2 * BYTE_BITS_SIZE;

  localparam logic [2:0] MODE_WORD = 3'b000;
  localparam logic [2:0] MODE_BYTE = 3'b001;
  localparam logic [2:0] MODE_HALF = 3'b010;
  localparam logic [2:0] MODE_LWL  = 3'b011;
  localparam logic [2:0] MODE_LWR  = 3'b100;

  function automatic logic [BITS_SIZE-1:0] extend_byte(input logic [BYTE_BITS_SIZE-1:0] b,
                                                        input logic zext);
    return {{(BITS_SIZE-BYTE_BITS_SIZE){~zext & b[BYTE_BITS_SIZE-1]}}, b};
  endfunction

  function automatic logic [BITS_SIZE-1:0] extend_half(input logic [HALF_W-1:0] h,
                                                        input logic zext);
    return {{(BITS_SIZE-HALF_W){~zext & h[HALF_W-1]}}, h};
  endfunction

`ifdef WB_UNALIGNED_EN
  localparam int LANES = BITS_SIZE / BYTE_BITS_SIZE;

  function automatic logic [BITS_SIZE-1:0] merge_lwl(input logic [BITS_SIZE-1:0] mem,
                                                      input logic [BITS_SIZE-1:0] rt,
                                                      input logic [1:0] off);
    int sh;
    sh = (LANES - 1 - int'(off)) * BYTE_BITS_SIZE;
    return (mem << sh) | (rt & ~({BITS_SIZE{1'b1}} << sh));
  endfunction

  function automatic logic [BITS_SIZE-1:0] merge_lwr(input logic [BITS_SIZE-1:0] mem,
                                                      input logic [BITS_SIZE-1:0] rt,
                                                      input logic [1:0] off);
    int sh;
    sh = int'(off) * BYTE_BITS_SIZE;
    return (mem >> sh) | (rt & ~({BITS_SIZE{1'b1}} >> sh));
  endfunction
`else
  logic unused_rt_old;
  assign unused_rt_old = ^i_rt_old;
`endif

  logic                  load_fault;
  logic [1:0]            fmt_off;
  logic [BITS_SIZE-1:0]  fmt_load;
  logic                  fault;
  logic [BITS_SIZE-1:0]  wr_data;

  logic                  valid_p1;
  logic                  reg_write_p1;
  logic [BITS_REGS-1:0]  rd_p1;
  logic [BITS_SIZE-1:0]  data_p1;
  logic                  fault_p1;
  logic [BITS_COUNT-1:0] retired_p1;

  // p0: decode fault and format the load; a faulting load is formatted as if aligned
  always_comb begin
    load_fault = 1'b0;
    case (i_load_mode)
      MODE_WORD: load_fault = (i_addr_offset != 2'b00);
      MODE_BYTE: load_fault = 1'b0;
      MODE_HALF: load_fault = i_addr_offset[0];
`ifdef WB_UNALIGNED_EN
      MODE_LWL, MODE_LWR: load_fault = 1'b0;
`endif
      default:   load_fault = 1'b1;
    endcase

    fmt_off  = load_fault ? 2'b00 : i_addr_offset;
    fmt_load = i_dato_mem;
    case (i_load_mode)
      MODE_BYTE: fmt_load = extend_byte(i_dato_mem[int'(fmt_off)*BYTE_BITS_SIZE +: BYTE_BITS_SIZE],
                                        i_zero_extend);
      MODE_HALF: fmt_load = extend_half(i_dato_mem[int'(fmt_off[1])*HALF_W +: HALF_W],
                                        i_zero_extend);
`ifdef WB_UNALIGNED_EN
      MODE_LWL:  fmt_load = merge_lwl(i_dato_mem, i_rt_old, fmt_off);
      MODE_LWR:  fmt_load = merge_lwr(i_dato_mem, i_rt_old, fmt_off);
`endif
      default:   fmt_load = i_dato_mem;
    endcase

    fault = i_valid & i_mem_to_reg & ~i_lui & load_fault;

    if (!i_mem_to_reg)
      wr_data = i_alu;
    else if (i_lui)
      wr_data = i_extension;
    else
      wr_data = fmt_load;
  end

  // p1: MEM/WB register; reset > stall > flush > capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_p1     <= 1'b0;
      reg_write_p1 <= 1'b0;
      rd_p1        <= '0;
      data_p1      <= '0;
      fault_p1     <= 1'b0;
      retired_p1   <= '0;
    end else if (!i_stall) begin
      if (i_flush) begin
        valid_p1     <= 1'b0;
        reg_write_p1 <= 1'b0;
        rd_p1        <= '0;
        data_p1      <= '0;
        fault_p1     <= 1'b0;
      end else begin
        valid_p1     <= i_valid;
        reg_write_p1 <= i_valid & i_reg_write & (i_rd != '0) & ~fault;
        rd_p1        <= i_rd;
        data_p1      <= wr_data;
        fault_p1     <= fault;
        if (i_valid && !fault)
          retired_p1 <= retired_p1 + BITS_COUNT'(1);
      end
    end
  end

  assign o_valid      = valid_p1;
  assign o_reg_write  = reg_write_p1;
  assign o_rd         = rd_p1;
  assign o_data_write = data_p1;
  assign o_fault      = fault_p1;
  assign o_retired    = retired_p1;

endmodule

// File: tb/tb_memwb_writeback_unit.sv
// Directed testbench for memwb_writeback_unit; counter width reduced to 8 bits so wrap is reachable.
module tb_memwb_writeback_unit;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_stall, i_flush, i_reg_write;
  logic [4:0]  i_rd;
  logic        i_mem_to_reg, i_lui, i_zero_extend;
  logic [2:0]  i_load_mode;
  logic [1:0]  i_addr_offset;
  logic [31:0] i_dato_mem, i_alu, i_extension, i_rt_old;
  logic        o_valid, o_reg_write, o_fault;
  logic [4:0]  o_rd;
  logic [31:0] o_data_write;
  logic [7:0]  o_retired;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_ret = 8'd0;

  always #5 i_clk = ~i_clk;

  memwb_writeback_unit #(
    .BITS_SIZE(32), .BITS_REGS(5), .BYTE_BITS_SIZE(8), .BITS_COUNT(8)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
    .i_flush(i_flush), .i_reg_write(i_reg_write), .i_rd(i_rd),
    .i_mem_to_reg(i_mem_to_reg), .i_lui(i_lui), .i_zero_extend(i_zero_extend),
    .i_load_mode(i_load_mode), .i_addr_offset(i_addr_offset),
    .i_dato_mem(i_dato_mem), .i_alu(i_alu), .i_extension(i_extension),
    .i_rt_old(i_rt_old), .o_valid(o_valid), .o_reg_write(o_reg_write),
    .o_rd(o_rd), .o_data_write(o_data_write), .o_fault(o_fault),
    .o_retired(o_retired)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_idle();
    i_reset = 0; i_valid = 0; i_stall = 0; i_flush = 0; i_reg_write = 0;
    i_rd = 0; i_mem_to_reg = 0; i_lui = 0; i_zero_extend = 0; i_load_mode = 0;
    i_addr_offset = 0; i_dato_mem = 0; i_alu = 0; i_extension = 0; i_rt_old = 0;
  endtask

  task automatic set_load(input logic [2:0] mode, input logic [1:0] off,
                          input logic zext, input logic [31:0] dato);
    set_idle();
    i_valid = 1; i_reg_write = 1; i_rd = 5'd7; i_mem_to_reg = 1;
    i_load_mode = mode; i_addr_offset = off; i_zero_extend = zext; i_dato_mem = dato;
  endtask

  task automatic test_reset();
    set_idle();
    i_reset = 1; i_valid = 1; i_reg_write = 1; i_rd = 5'd3; i_alu = 32'hDEADBEEF;
    step();
    checks++;
    if ({o_valid, o_reg_write, o_fault} !== 3'b000 || o_rd !== 5'd0 ||
        o_data_write !== 32'h0 || o_retired !== 8'd0) begin
      failures++;
      $display("FAIL reset got v=%b w=%b f=%b rd=%0d d=%h r=%0d exp all zero",
               o_valid, o_reg_write, o_fault, o_rd, o_data_write, o_retired);
    end
    exp_ret = 0;
  endtask

  task automatic test_alu();
    set_idle();
    i_valid = 1; i_reg_write = 1; i_rd = 5'd4; i_alu = 32'h12345678;
    i_extension = 32'hAAAA0000; i_dato_mem = 32'h55555555;
    for (int n = 0; n < 3; n++) begin
      step();
      exp_ret++;
      checks++;
      if (o_data_write !== 32'h12345678 || o_reg_write !== 1'b1 || o_rd !== 5'd4 ||
          o_valid !== 1'b1) begin
        failures++;
        $display("FAIL alu_%0d got d=%h w=%b rd=%0d v=%b exp d=12345678 w=1 rd=4 v=1",
                 n, o_data_write, o_reg_write, o_rd, o_valid);
      end
    end
    checks++;
    if (o_retired !== 8'd3) begin
      failures++;
      $display("FAIL alu_retired got=%0d exp=3", o_retired);
    end
    i_mem_to_reg = 1; i_lui = 1;
    step();
    exp_ret++;
    checks++;
    if (o_data_write !== 32'hAAAA0000) begin
      failures++;
      $display("FAIL lui got=%h exp=aaaa0000", o_data_write);
    end
  endtask

  task automatic test_byte_load();
    set_load(3'b001, 2'd3, 1'b0, 32'h80FF7F01);
    step();
    exp_ret++;
    checks++;
    if (o_data_write !== 32'hFFFFFF80 || o_fault !== 1'b0 || o_reg_write !== 1'b1) begin
      failures++;
      $display("FAIL byte_sext got d=%h f=%b w=%b exp d=ffffff80 f=0 w=1",
               o_data_write, o_fault, o_reg_write);
    end
    i_zero_extend = 1;
    step();
    exp_ret++;
    checks++;
    if (o_data_write !== 32'h00000080) begin
      failures++;
      $display("FAIL byte_zext got=%h exp=00000080", o_data_write);
    end
    i_zero_extend = 0; i_addr_offset = 2'd2;
    step();
    exp_ret++;
    checks++;
    if (o_data_write !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL byte_off2 got=%h exp=ffffffff", o_data_write);
    end
    i_addr_offset = 2'd1;
    step();
    exp_ret++;
    checks++;
    if (o_data_write !== 32'h0000007F) begin
      failures++;
      $display("FAIL byte_off1 got=%h exp=0000007f", o_data_write);
    end
  endtask

  task automatic test_half_load();
    set_load(3'b010, 2'd2, 1'b0, 32'hBEEF1234);
    step();
    exp_ret++;
    checks++;
    if (o_data_write !== 32'hFFFFBEEF || o_fault !== 1'b0) begin
      failures++;
      $display("FAIL half_off2 got d=%h f=%b exp d=ffffbeef f=0", o_data_write, o_fault);
    end
    i_addr_offset = 2'd0;
    step();
    exp_ret++;
    checks++;
    if (o_data_write !== 32'h00001234) begin
      failures++;
      $display("FAIL half_off0 got=%h exp=00001234", o_data_write);
    end
    i_addr_offset = 2'd1;
    step();
    checks++;
    if (o_fault !== 1'b1 || o_reg_write !== 1'b0 || o_retired !== exp_ret ||
        o_data_write !== 32'h00001234) begin
      failures++;
      $display("FAIL half_fault got f=%b w=%b r=%0d d=%h exp f=1 w=0 r=%0d d=00001234",
               o_fault, o_reg_write, o_retired, o_data_write, exp_ret);
    end
    set_idle();
    step();
    checks++;
    if (o_fault !== 1'b0 || o_valid !== 1'b0 || o_reg_write !== 1'b0) begin
      failures++;
      $display("FAIL fault_one_cycle got f=%b v=%b w=%b exp 0 0 0", o_fault, o_valid, o_reg_write);
    end
  endtask

  task automatic test_word_fault();
    set_load(3'b000, 2'd0, 1'b0, 32'hCAFEF00D);
    step();
    exp_ret++;
    checks++;
    if (o_data_write !== 32'hCAFEF00D || o_fault !== 1'b0) begin
      failures++;
      $display("FAIL word_ok got d=%h f=%b exp d=cafef00d f=0", o_data_write, o_fault);
    end
    i_addr_offset = 2'd2;
    step();
    checks++;
    if (o_fault !== 1'b1 || o_reg_write !== 1'b0 || o_retired !== exp_ret) begin
      failures++;
      $display("FAIL word_fault got f=%b w=%b r=%0d exp f=1 w=0 r=%0d",
               o_fault, o_reg_write, o_retired, exp_ret);
    end
    i_load_mode = 3'b101; i_addr_offset = 2'd0;
    step();
    checks++;
    if (o_fault !== 1'b1 || o_reg_write !== 1'b0) begin
      failures++;
      $display("FAIL illegal_mode got f=%b w=%b exp f=1 w=0", o_fault, o_reg_write);
    end
    i_mem_to_reg = 0; i_alu = 32'h00000042;
    step();
    exp_ret++;
    checks++;
    if (o_fault !== 1'b0 || o_reg_write !== 1'b1 || o_data_write !== 32'h00000042) begin
      failures++;
      $display("FAIL alu_no_fault got f=%b w=%b d=%h exp f=0 w=1 d=00000042",
               o_fault, o_reg_write, o_data_write);
    end
  endtask

  task automatic test_stall_flush();
    set_idle();
    i_valid = 1; i_reg_write = 1; i_rd = 5'd9; i_alu = 32'h0BADCAFE;
    step();
    exp_ret++;
    i_stall = 1; i_rd = 5'd10; i_alu = 32'h11111111;
    for (int n = 0; n < 2; n++) begin
      step();
      checks++;
      if (o_data_write !== 32'h0BADCAFE || o_rd !== 5'd9 || o_retired !== exp_ret ||
          o_valid !== 1'b1 || o_reg_write !== 1'b1) begin
        failures++;
        $display("FAIL stall_%0d got d=%h rd=%0d r=%0d exp d=0badcafe rd=9 r=%0d",
                 n, o_data_write, o_rd, o_retired, exp_ret);
      end
    end
    i_flush = 1;
    step();
    checks++;
    if (o_data_write !== 32'h0BADCAFE || o_valid !== 1'b1 || o_retired !== exp_ret) begin
      failures++;
      $display("FAIL stall_flush got d=%h v=%b r=%0d exp d=0badcafe v=1 r=%0d",
               o_data_write, o_valid, o_retired, exp_ret);
    end
    i_stall = 0;
    step();
    checks++;
    if (o_valid !== 1'b0 || o_reg_write !== 1'b0 || o_rd !== 5'd0 ||
        o_data_write !== 32'h0 || o_retired !== exp_ret) begin
      failures++;
      $display("FAIL flush got v=%b w=%b rd=%0d d=%h r=%0d exp 0 0 0 0 r=%0d",
               o_valid, o_reg_write, o_rd, o_data_write, o_retired, exp_ret);
    end
  endtask

  task automatic test_rd_zero();
    set_idle();
    i_valid = 1; i_reg_write = 1; i_rd = 5'd0; i_alu = 32'h00000077;
    step();
    exp_ret++;
    checks++;
    if (o_reg_write !== 1'b0 || o_valid !== 1'b1 || o_retired !== exp_ret) begin
      failures++;
      $display("FAIL rd_zero got w=%b v=%b r=%0d exp w=0 v=1 r=%0d",
               o_reg_write, o_valid, o_retired, exp_ret);
    end
    i_rd = 5'd5; i_reg_write = 0;
    step();
    exp_ret++;
    checks++;
    if (o_reg_write !== 1'b0 || o_retired !== exp_ret) begin
      failures++;
      $display("FAIL no_regwrite got w=%b r=%0d exp w=0 r=%0d", o_reg_write, o_retired, exp_ret);
    end
  endtask

  task automatic test_unaligned();
    set_load(3'b011, 2'd1, 1'b0, 32'hAABBCCDD);
    i_rt_old = 32'h11223344;
    step();
`ifdef WB_UNALIGNED_EN
    exp_ret++;
    checks++;
    if (o_data_write !== 32'hCCDD3344 || o_fault !== 1'b0 || o_reg_write !== 1'b1) begin
      failures++;
      $display("FAIL lwl got d=%h f=%b exp d=ccdd3344 f=0", o_data_write, o_fault);
    end
`else
    checks++;
    if (o_fault !== 1'b1 || o_reg_write !== 1'b0 || o_retired !== exp_ret) begin
      failures++;
      $display("FAIL lwl_illegal got f=%b w=%b r=%0d exp f=1 w=0 r=%0d",
               o_fault, o_reg_write, o_retired, exp_ret);
    end
`endif
    i_load_mode = 3'b100;
    step();
`ifdef WB_UNALIGNED_EN
    exp_ret++;
    checks++;
    if (o_data_write !== 32'h11AABBCC || o_fault !== 1'b0) begin
      failures++;
      $display("FAIL lwr got d=%h f=%b exp d=11aabbcc f=0", o_data_write, o_fault);
    end
`else
    checks++;
    if (o_fault !== 1'b1 || o_reg_write !== 1'b0) begin
      failures++;
      $display("FAIL lwr_illegal got f=%b w=%b exp f=1 w=0", o_fault, o_reg_write);
    end
`endif
  endtask

  task automatic test_wrap();
    set_idle();
    i_valid = 1; i_reg_write = 1; i_rd = 5'd1;
    while (exp_ret != 8'hFF) begin
      step();
      exp_ret++;
    end
    checks++;
    if (o_retired !== 8'hFF) begin
      failures++;
      $display("FAIL retired_full got=%0d exp=255", o_retired);
    end
    step();
    exp_ret++;
    checks++;
    if (o_retired !== 8'h00) begin
      failures++;
      $display("FAIL retired_wrap got=%0d exp=0", o_retired);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_idle();
    i_valid = 1; i_reg_write = 1; i_rd = 5'd6; i_alu = 32'h5A5A5A5A;
    step();
    i_stall = 1;
    step();
    i_reset = 1;
    step();
    checks++;
    if ({o_valid, o_reg_write, o_fault} !== 3'b000 || o_rd !== 5'd0 ||
        o_data_write !== 32'h0 || o_retired !== 8'd0) begin
      failures++;
      $display("FAIL reset_in_stall got v=%b w=%b rd=%0d d=%h r=%0d exp all zero",
               o_valid, o_reg_write, o_rd, o_data_write, o_retired);
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_alu();
    test_byte_load();
    test_half_load();
    test_word_fault();
    test_stall_flush();
    test_rd_zero();
    test_unaligned();
    test_wrap();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memwb_writeback_unit.md
# memwb_writeback_unit

Parametrised MEM/WB pipeline register with registered load formatting, byte-lane selection and write-back gating for the MIPS core. Sits between the data-memory stage and the register file. Replaces the purely combinational write-back mux with the following additions:
- address-offset lane selection;
- misalignment fault detection;
- optional LWL/LWR merging;
- stall/flush handshake;
- a retired-instruction counter for the debug unit.

## Interface
Parameters:
- BITS_SIZE, 32, datapath width (must be 32 when unaligned merge is compiled in)
- BITS_REGS, 5, register index width
- BYTE_BITS_SIZE, 8, byte width
- BITS_COUNT, 32, retired-counter width

Ports:
- i_clk  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  MEM stage presents an instruction
- i_stall  in  1  hold all state and outputs
- i_flush  in  1  squash the instruction being captured
- i_reg_write  in  1  instruction writes the register file
- i_rd  in  BITS_REGS  destination register
- i_mem_to_reg  in  1  select the load/LUI path instead of the ALU result
- i_lui  in  1  select i_extension on the load path
- i_zero_extend  in  1  zero-extend byte/half loads (0 = sign-extend)
- i_load_mode  in  3  000 word, 001 byte, 010 half, 011 LWL, 100 LWR; others illegal
- i_addr_offset  in  2  low address bits of the load
- i_dato_mem  in  BITS_SIZE  raw memory word
- i_alu  in  BITS_SIZE  ALU result
- i_extension  in  BITS_SIZE  LUI immediate, already shifted
- i_rt_old  in  BITS_SIZE  current rt value for LWL/LWR merge
- o_valid  out  1  registered instruction valid
- o_reg_write  out  1  register-file write enable
- o_rd  out  BITS_REGS  destination register
- o_data_write  out  BITS_SIZE  write data
- o_fault  out  1  misaligned or illegal load, one per faulting instruction
- o_retired  out  BITS_COUNT  count of valid, non-faulting instructions captured

## Operation
- Event priority on each clock edge: i_reset > i_stall > i_flush > capture.
- Reset: every output and the counter go to 0.
- Stall: all registers hold, including the counter.
- Flush without stall:
  - o_valid, o_reg_write and o_fault are cleared;
  - o_rd and o_data_write are cleared to 0;
  - the counter holds.
- Capture without stall or flush: o_valid <= i_valid. When i_valid=0, o_reg_write and o_fault are cleared.
- Lane selection is little-endian: byte k = i_dato_mem[8k+7:8k].
- Byte load: select lane i_addr_offset, then zero- or sign-extend to BITS_SIZE.
- Half load:
  - offset 0 selects [15:0]; offset 2 selects [31:16]; then extend;
  - offset 1 or 3 is a fault.
- Word load: any nonzero offset is a fault.
- Data select, in order:
  - i_mem_to_reg=0 → i_alu;
  - i_lui=1 → i_extension;
  - otherwise the formatted load.
- Fault is evaluated only when i_mem_to_reg=1, i_lui=0 and i_valid=1.
- On fault:
  - o_fault=1 and o_reg_write=0;
  - o_data_write is the formatted value with the offset ignored (not consumed);
  - the counter does not increment.
- o_reg_write = i_valid & i_reg_write & (i_rd != 0) & ~fault.
- The counter increments on each capture with i_valid=1 and no fault, whether or not the instruction writes a register. It wraps from all-ones to 0.

## Timing
- Latency is 1 cycle: inputs sampled on edge N appear on the outputs after edge N.
- No combinational path from inputs to outputs.
- o_fault lasts exactly one cycle per faulting instruction, or longer only while stalled.
- i_stall and i_flush asserted on the same edge: the stall wins and the flush is lost. The upstream hazard unit must re-assert the flush.
- Reset asserted mid-stall clears the state on that same edge.

## Configuration
- WB_UNALIGNED_EN is defined:
  - LWL at offset k: (i_dato_mem << 8·(3−k)) | (i_rt_old & low-mask of 8·(3−k) bits);
  - LWR at offset k: (i_dato_mem >> 8k) | (i_rt_old & ~(all-ones >> 8k));
  - neither mode ever faults.
- WB_UNALIGNED_EN is not defined:
  - modes 011 and 100 are treated as illegal (fault, no write);
  - i_rt_old is unused.

## Test plan
- Reset, then 3 captures of ALU ops (i_alu=0x12345678, rd=4) → o_data_write=0x12345678 one cycle later, o_reg_write=1, o_retired=3.
- Byte load, dato=0x80FF7F01, offset 3, sign-extend → 0xFFFFFF80. The same load with zero-extend → 0x00000080.
- Half load, dato=0xBEEF1234: offset 2, sign-extend → 0xFFFFBEEF. Offset 1 → o_fault=1, o_reg_write=0, o_retired unchanged.
- Stall for 2 cycles mid-stream → outputs and o_retired are frozen. Stall and flush on the same edge → instruction still held. Flush alone → o_valid=0, o_reg_write=0.
- Write to rd=0 with i_reg_write=1 → o_reg_write=0, o_retired increments. Preload counter to all-ones via 2^32−1 captures, or via a forced register → the next capture gives 0.
- Macro defined: LWL with dato=0xAABBCCDD, rt=0x11223344, offset 1 → 0xCCDD3344. LWR at offset 1 → 0x11AABBCC. Macro undefined: same stimulus → o_fault=1.
